// File: rtl/ptp_ts_pkg.sv
// Shared constants for the timestamp aggregator: record layout, default widths
// and a constant-foldable clog2 used to size pointers and tags.
package ptp_ts_pkg;

    localparam int TS_W_DEF = 128;

    // Record layout as packed by the timestamp unit queue.
    localparam int TS_NS_LSB    = 0;
    localparam int TS_NS_W      = 32;
    localparam int TS_SEC_LSB   = 32;
    localparam int TS_SEC_W     = 48;
    localparam int TS_SEQID_LSB = 80;
    localparam int TS_SEQID_W   = 16;
    localparam int TS_MSGID_LSB = 96;
    localparam int TS_MSGID_W   = 4;

    localparam int                        DROP_CNT_W_DEF = 16;
    localparam logic [DROP_CNT_W_DEF-1:0] DROP_SAT_DEF   = '1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ptp_ts_aggr_if.sv
// Bus between the timestamp sources / register block and the aggregator.
interface ptp_ts_aggr_if
    import ptp_ts_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = DROP_CNT_W_DEF
);
    localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int QC_W = clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH*TS_W-1:0]  ch_data;
    logic                    q_rd_en;
    logic                    q_clr;
    logic                    q_rd_vld;
    logic [TS_W-1:0]         q_rd_data;
    logic [CH_W-1:0]         q_rd_ch;
    logic [QC_W-1:0]         q_count;
    logic                    q_ovf;
    logic [NUM_CH*CNT_W-1:0] drop_cnt;

    modport master (
        output ch_en, ch_valid, ch_data, q_rd_en, q_clr,
        input  q_rd_vld, q_rd_data, q_rd_ch, q_count, q_ovf, drop_cnt
    );

    modport slave (
        input  ch_en, ch_valid, ch_data, q_rd_en, q_clr,
        output q_rd_vld, q_rd_data, q_rd_ch, q_count, q_ovf, drop_cnt
    );

endinterface

// File: rtl/ptp_ts_sfifo.sv
// Synchronous show-ahead FIFO; head word is presented whenever not empty, zero otherwise.
module ptp_ts_sfifo
    import ptp_ts_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   count
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;

    // A write into a full FIFO is legal only when the head leaves the same cycle.
    assign do_rd = rd_en && !empty && !clr;
    assign do_wr = wr_en && (!full || do_rd) && !clr;

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ptp_ts_aggr.sv
// Merges NUM_CH timestamp sources into one shared show-ahead queue with
// round-robin arbitration, per-channel holding registers and drop accounting.
module ptp_ts_aggr
    import ptp_ts_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = DROP_CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    ptp_ts_aggr_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int AW    = clog2(DEPTH);
    localparam int REC_W = TS_W + CH_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] load;
    logic [TS_W-1:0]   data_q [NUM_CH];
    logic [CNT_W-1:0]  drop_q [NUM_CH];
    logic [CNT_W-1:0]  drop_d [NUM_CH];
    logic              ovf_q, ovf_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx;
    logic              wr_ok, pop;
    logic              fifo_empty, fifo_full;
    logic [AW:0]       fifo_count;
    logic [REC_W-1:0]  fifo_rd_data;

    assign pop   = bus.q_rd_en && !fifo_empty;
    assign wr_ok = !fifo_full || pop;

    // Walk downward so the pending channel closest to rr_q overwrites the others.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
        if (!wr_ok || bus.q_clr) gnt_vld = 1'b0;
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

    // A strobe is accepted when the holding slot is free or drains this cycle.
    always_comb begin
        logic granted;
        granted = 1'b0;
        pend_d  = pend_q;
        load    = '0;
        ovf_d   = ovf_q;
        for (int k = 0; k < NUM_CH; k++) begin
            drop_d[k] = drop_q[k];
            granted   = gnt_vld && (gnt_idx == CH_W'(k));
            if (!bus.ch_en[k]) begin
                pend_d[k] = 1'b0;
            end else if (bus.ch_valid[k]) begin
                if (!pend_q[k] || granted) begin
                    pend_d[k] = 1'b1;
                    load[k]   = 1'b1;
                end else begin
                    if (drop_q[k] != CNT_MAX) drop_d[k] = drop_q[k] + CNT_W'(1);
                    ovf_d = 1'b1;
                end
            end else if (granted) begin
                pend_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
            rr_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) drop_q[k] <= '0;
        end else if (bus.q_clr) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) drop_q[k] <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            rr_q   <= rr_d;
            for (int k = 0; k < NUM_CH; k++) drop_q[k] <= drop_d[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (load[k]) data_q[k] <= bus.ch_data[k*TS_W +: TS_W];
        end
    end

    ptp_ts_sfifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.q_clr),
        .wr_en   (gnt_vld),
        .wr_data ({gnt_idx, data_q[gnt_idx]}),
        .rd_en   (bus.q_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.q_rd_vld  = !fifo_empty;
    assign bus.q_rd_data = fifo_rd_data[TS_W-1:0];
    assign bus.q_rd_ch   = fifo_rd_data[REC_W-1 -: CH_W];
    assign bus.q_count   = fifo_count;
    assign bus.q_ovf     = ovf_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_drop
        assign bus.drop_cnt[k*CNT_W +: CNT_W] = drop_q[k];
    end

endmodule
